// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin sharing of one start/done FP multiplier among NUM_REQ requesters.
// Optional WAIT-state abort after TIMEOUT_CYC cycles is built when FP_ARB_TIMEOUT_EN is defined.
module fp_mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      mult_start,
    output logic [DATA_W-1:0]         mult_a,
    output logic [DATA_W-1:0]         mult_b,
    input  logic                      mult_done,
    input  logic [DATA_W-1:0]         mult_result,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // Handshake: gnt, mult_start and rsp_valid are single-cycle one-hot pulses; the multiplier
    // owns mult_done as a level and only its 0->1 transition (seen in WAIT) completes an op.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
        $error("fp_mult_arbiter: parameter out of supported range");
    end

    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return PTR_W'(sum);
    endfunction

    state_t               r_state;
    state_t               w_next;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic                 r_done_dly;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_mult_start;
    logic [DATA_W-1:0]    r_mult_a;
    logic [DATA_W-1:0]    r_mult_b;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data;
    logic                 w_found;
    logic [PTR_W-1:0]     w_pick;
    logic                 w_done_rise;
    logic                 w_timeout;

    assign w_done_rise = mult_done & ~r_done_dly;

`ifdef FP_ARB_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_rsp_err;

    // Fires on the WAIT cycle whose increment would bring the count to TIMEOUT_CYC.
    assign w_timeout = ((r_wait_cnt + 8'd1) == 8'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == S_WAIT && (w_done_rise || w_timeout)) begin
            r_rsp_err <= ~w_done_rise;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // First requester at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[rot_idx(r_rr_ptr, i)]) begin
                w_found = 1'b1;
                w_pick  = rot_idx(r_rr_ptr, i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_done_rise || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_done_dly   <= 1'b0;
            r_gnt        <= '0;
            r_mult_start <= 1'b0;
            r_mult_a     <= '0;
            r_mult_b     <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
        end else begin
            r_done_dly   <= mult_done;
            r_gnt        <= '0;
            r_mult_start <= 1'b0;
            r_rsp_valid  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner  <= w_pick;
                        r_mult_a <= req_a[int'(w_pick)*DATA_W +: DATA_W];
                        r_mult_b <= req_b[int'(w_pick)*DATA_W +: DATA_W];
                        r_gnt    <= NUM_REQ'(1) << w_pick;
                        r_rr_ptr <= rot_idx(w_pick, 1);
                    end
                end
                S_ISSUE: r_mult_start <= 1'b1;
                S_WAIT: begin
                    // A coincident done edge beats the timeout and returns real data.
                    if (w_done_rise || w_timeout) begin
                        r_rsp_valid <= NUM_REQ'(1) << r_owner;
                        r_rsp_data  <= w_done_rise ? mult_result : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign mult_start = r_mult_start;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

endmodule
